// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch port and a load/store port; ports: clk/reset, i_req/i_addr/i_ack/i_rdata, d_req/d_we/d_addr/d_wdata/d_ack/d_rdata, mem_addr/mem_data/mem_MW/mem_MD/mem_out, busy
module mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_ack,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ack,
  output logic [WIDTH-1:0] d_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_data,
  output logic             mem_MW,
  output logic             mem_MD,
  input  logic [WIDTH-1:0] mem_out,
  output logic             busy
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sc_q, sc_d;
  logic gnt_i_q, gnt_i_d, we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic starve, pick_i;
  assign starve = sc_q == LIM;
  assign pick_i = i_req & (~d_req | starve);
  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    gnt_i_d   = gnt_i_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: if (i_req | d_req) begin
        state_d = ACCESS;
        gnt_i_d = pick_i;
        we_d    = ~pick_i & d_we;
        addr_d  = pick_i ? i_addr : d_addr;
        wdata_d = d_wdata;
        sc_d    = (pick_i | ~i_req) ? '0 : (starve ? sc_q : sc_q + 1'b1);
      end
      ACCESS: begin
        state_d   = DONE;
        i_rdata_d = (~we_q & gnt_i_q) ? mem_out : i_rdata_q;
        d_rdata_d = (~we_q & ~gnt_i_q) ? mem_out : d_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sc_q      <= '0;
      gnt_i_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      sc_q      <= sc_d;
      gnt_i_q   <= gnt_i_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign i_ack    = (state_q == DONE) & gnt_i_q;
  assign d_ack    = (state_q == DONE) & ~gnt_i_q;
  assign mem_MW   = (state_q == ACCESS) & we_q & ~reset;
  assign mem_MD   = (state_q == ACCESS) & ~we_q & ~reset;
  assign mem_addr = addr_q;
  assign mem_data = wdata_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single-port data memory (`clk`, address, data, MW write-enable, MD read-enable, out). It shares the memory between an instruction-fetch port (read-only) and a load/store port (read or write). It runs each granted access as a fixed three-state sequence and returns read data through per-port registers with a one-cycle acknowledge. It sits between the CPU front end / execute stage and the memory instance.

## Interface
- `WIDTH`, 32: address and data width.
- `STARVE_LIMIT`, 4: maximum consecutive data-port grants while the instruction port is waiting (≥1).

Ports (clock and reset first):
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock; reset polarity and synchronicity fixed.
- `i_req`  in  1  instruction read request; level, held until `i_ack`.
- `i_addr`  in  WIDTH  instruction address; stable while `i_req` high.
- `i_ack`  out  1  one-cycle pulse: instruction read complete.
- `i_rdata`  out  WIDTH  last instruction read data (registered).
- `d_req`  in  1  data request; level, held until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`, `d_wdata`  in  WIDTH  data address / write data; stable while `d_req` high.
- `d_ack`  out  1  one-cycle pulse: data access complete.
- `d_rdata`  out  WIDTH  last data-port read data (registered).
- `mem_addr`, `mem_data`  out  WIDTH  to memory address / data.
- `mem_MW`  out  1  memory write enable.
- `mem_MD`  out  1  memory read enable.
- `mem_out`  in  WIDTH  memory read data (valid combinationally while `mem_MD`=1).
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE → ACCESS → DONE → IDLE. No other transitions.
- IDLE: requests sampled only here. If neither `i_req` nor `d_req` is high, stay in IDLE. Otherwise latch grant, address, write data and we (forced 0 for instruction) into registers and go to ACCESS.
- Arbitration: the data port wins by default. A starvation counter `sc` (saturating at STARVE_LIMIT):
  - increments on a data grant with `i_req` high;
  - clears on an instruction grant, or on a data grant with `i_req` low.
  - If `sc == STARVE_LIMIT` and `i_req` is high, the instruction port wins even when `d_req` is high.
- ACCESS: `mem_addr`/`mem_data` come from the latched registers; `mem_MW` = latched we; `mem_MD` = ~latched we. At the end of the cycle, a read captures `mem_out` into the granted port's rdata register. Go to DONE.
- DONE: the granted port's ack is 1 for exactly this cycle. Go to IDLE unconditionally.
- Outside ACCESS: `mem_MW`=0 and `mem_MD`=0; `mem_addr`/`mem_data` hold their last latched values.
- `i_rdata`/`d_rdata` change only on that port's read completion. A data write leaves `d_rdata` unchanged.
- Requester contract: keep req and operands stable from assertion through the ack cycle. If req is still high in the IDLE cycle after DONE, that is a new request using the current operands.

## Timing
- Reset (edge with `reset`=1): state IDLE, `sc`=0, all latched registers 0.
  - Outputs: `i_ack`=`d_ack`=0, `i_rdata`=`d_rdata`=0, `mem_addr`=`mem_data`=0, `mem_MW`=`mem_MD`=0, `busy`=0.
- Reset mid-operation: `mem_MW` and `mem_MD` are combinationally gated by ~`reset`, so no write is committed in a cycle where reset is high. Any pending ack is dropped and the requester must re-request.
- Latency: req high in IDLE cycle N → ACCESS in N+1 → ack in N+2 → IDLE in N+3. Minimum 3 cycles per access; back-to-back throughput is 1 access per 3 cycles.
- Write commit: the memory writes at the rising edge that ends the ACCESS cycle.
- Simultaneous `i_req` and `d_req` in IDLE: exactly one grant per the arbitration rule. The loser keeps waiting and is not acked.
- `i_ack` and `d_ack` are never high in the same cycle. `busy` = (state ≠ IDLE).

## Test plan
- Reset: hold `reset`=1 for 2 cycles with both reqs high → all outputs 0, no `mem_MW`/`mem_MD` pulse, `busy`=0.
- Data write then read:
  - `d_req`=1, `d_we`=1, `d_addr`=2, `d_wdata`=5 → `mem_MW`=1 with `mem_addr`=2, `mem_data`=5 for one cycle; `d_ack` 2 cycles after request.
  - Then read addr 2 → `mem_MD`=1 one cycle; `d_rdata`=5 with `d_ack`.
- Instruction read: preload addr 5 = 0x0000_0005; `i_req`=1, `i_addr`=5 → `i_rdata`=5, `i_ack` at N+2. `mem_MW` never asserted; `d_rdata` unchanged.
- Collision: `i_req` and `d_req` (read addr 2) both high in IDLE → data granted first, `d_ack` at N+2. Instruction granted at N+3, `i_ack` at N+5.
- Starvation (STARVE_LIMIT=4): hold `d_req`=1 and `i_req`=1 continuously → grant order D,D,D,D,I,D,D,D,D,I. `sc` reads 0 after each instruction grant.
- Reset during write ACCESS (`d_addr`=7, `d_wdata`=9, reset asserted in the ACCESS cycle) → addr 7 keeps its prior value, no `d_ack`, state IDLE next cycle.
